bin2bcd_hex: RTL and testbench



---
 rtl/bin2bcd_hex_pkg.sv | 28 ++
 rtl/bin2bcd_hex_seg7_decode.sv | 30 +++
 rtl/bin2bcd_hex.sv | 157 +++++++++++++++
 tb/tb_bin2bcd_hex.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_hex_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_hex_pkg
// Shared definitions for the binary-to-BCD display stage:
//   - FSM state encoding for the double-dabble sequencer
//   - active-low 7-segment patterns, bit order g..a (bit 6 = g)
// -----------------------------------------------------------------------------
package bin2bcd_hex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/bin2bcd_hex_seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD digit to active-low 7-segment decoder.
//   i_bcd : 4-bit BCD digit
//   o_seg : segments g..a, active-low; non-decimal codes show blank
// -----------------------------------------------------------------------------
module seg7_decode
    import bin2bcd_hex_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bin2bcd_hex.sv
// -----------------------------------------------------------------------------
// bin2bcd_hex
// Sequential double-dabble converter feeding active-low 7-segment digits.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   load  : one-cycle strobe, samples value and starts a conversion when idle
//   value : binary input (WIDTH bits)
//   busy  : high while a conversion is in flight
//   done  : one-cycle pulse when bcd/hex update
//   bcd   : packed BCD result, digit 0 in [3:0]
//   hex   : active-low segments, digit i in [7i+6:7i]
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for load; outputs hold last completed result
// ST_SHIFT | WIDTH add-3/shift steps of {scratch, shreg}
// ST_FIN   | publish scratch to bcd/hex, pulse done
// -----------------------------------------------------------------------------
module bin2bcd_hex
    import bin2bcd_hex_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Digit 0 shows "0" out of reset; upper digits follow the blanking mode.
    function automatic logic [7*DIGITS-1:0] hex_reset();
        logic [7*DIGITS-1:0] v;
        v = '0;
        for (int i = 0; i < DIGITS; i++) begin
            v[7*i +: 7] = (i > 0 && BLANK_LZ != 0) ? SEG_BLANK : SEG_0;
        end
        return v;
    endfunction

    state_t                r_state;
    logic [WIDTH-1:0]      r_shreg;
    logic [4*DIGITS-1:0]   r_scratch;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [7*DIGITS-1:0]   r_hex;

    logic [4*DIGITS-1:0]   w_scratch_next;
    logic [3:0]            w_dig;
    logic [7*DIGITS-1:0]   w_seg;
    logic [7*DIGITS-1:0]   w_hex_next;
    logic                  w_run;

    // Add-3 on every digit from its pre-adjust value, then shift left by one
    // with the shreg MSB entering bit 0. The top digit's carry-out is dropped;
    // it cannot be set when 10^DIGITS > 2^WIDTH-1.
    always_comb begin
        w_scratch_next    = '0;
        w_dig             = '0;
        w_scratch_next[0] = r_shreg[WIDTH-1];
        for (int i = 0; i < DIGITS; i++) begin
            w_dig = r_scratch[4*i +: 4];
            if (w_dig >= 4'd5) begin
                w_dig = w_dig + 4'd3;
            end
            for (int b = 0; b < 4; b++) begin
                if (4*i + b + 1 < 4*DIGITS) begin
                    w_scratch_next[4*i + b + 1] = w_dig[b];
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dec
            seg7_decode u_dec (
                .i_bcd (r_scratch[4*g +: 4]),
                .o_seg (w_seg[7*g +: 7])
            );
        end
    endgenerate

    // Walk from the top digit down; w_run stays high while every digit seen
    // so far is zero. Digit 0 is never visited, so it always shows.
    always_comb begin
        w_run      = 1'b1;
        w_hex_next = w_seg;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_run = w_run & (r_scratch[4*i +: 4] == 4'd0);
            if (BLANK_LZ != 0 && w_run) begin
                w_hex_next[7*i +: 7] = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_hex     <= hex_reset();
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_shreg   <= value;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= w_scratch_next;
                    r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_bcd   <= r_scratch;
                    r_hex   <= w_hex_next;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;
    assign hex  = r_hex;

endmodule

// File: tb/tb_bin2bcd_hex.sv
module tb_bin2bcd_hex;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [7:0]  value;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [20:0] hex;

    int total = 0;
    int bad   = 0;
    int n_done = 0;
    int exp_q[$];

    bin2bcd_hex #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (value),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .hex   (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10];
        tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100;
        tbl[3] = 7'b0110000; tbl[4] = 7'b0011001; tbl[5] = 7'b0010010;
        tbl[6] = 7'b0000010; tbl[7] = 7'b1111000; tbl[8] = 7'b0000000;
        tbl[9] = 7'b0010000;
        return tbl[d];
    endfunction

    function automatic logic [11:0] bcd_model(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [20:0] hex_model(input int v);
        int h, t, o;
        logic [20:0] r;
        h = v / 100; t = (v / 10) % 10; o = v % 10;
        r[6:0]   = seg_of(o);
        r[13:7]  = (h == 0 && t == 0) ? 7'h7F : seg_of(t);
        r[20:14] = (h == 0) ? 7'h7F : seg_of(h);
        return r;
    endfunction

    // Scoreboard: every done pops the oldest expected value.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("bcd", {20'd0, bcd}, {20'd0, bcd_model(e)});
                chk("hex", {11'd0, hex}, {11'd0, hex_model(e)});
            end
        end
    end

    // Call at a negedge: strobe load for one cycle, then scramble value.
    task automatic do_load(input int v, input bit push);
        load  = 1'b1;
        value = 8'(v);
        if (push) exp_q.push_back(v);
        @(negedge clk);
        load  = 1'b0;
        value = 8'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int k = 0; k < 50; k++) begin
            if (done) break;
            if (busy) cyc++;
            @(negedge clk);
        end
        if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int d0;
        rst_n = 1'b0;
        load  = 1'b0;
        value = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bcd",  {20'd0, bcd}, 32'h000);
        chk("rst_hex",  {11'd0, hex}, {11'd0, 7'h7F, 7'h7F, 7'b1000000});

        // Max value, latency and single done pulse
        do_load(255, 1'b1);
        wait_done(cyc);
        chk("busy_cycles_255", cyc, 9);
        chk("bcd_255", {20'd0, bcd}, 32'h255);
        @(negedge clk);
        chk("done_width", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Interior zeros, then leading-zero blanking
        do_load(100, 1'b1);
        wait_done(cyc);
        chk("hex_100", {11'd0, hex}, {11'd0, 7'b1111001, 7'b1000000, 7'b1000000});
        @(negedge clk);
        do_load(7, 1'b1);
        wait_done(cyc);
        chk("hex_7", {11'd0, hex}, {11'd0, 7'h7F, 7'h7F, 7'b1111000});
        @(negedge clk);

        // Load while busy is dropped
        d0 = n_done;
        do_load(4, 1'b1);
        repeat (2) @(negedge clk);
        do_load(200, 1'b0);
        wait_done(cyc);
        chk("bcd_4", {20'd0, bcd}, 32'h004);
        repeat (15) @(negedge clk);
        chk("drop_done_count", n_done - d0, 1);
        chk("drop_bcd_hold", {20'd0, bcd}, 32'h004);

        // Reset mid-SHIFT aborts the conversion
        do_load(255, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_bcd",  {20'd0, bcd}, 32'h000);
        chk("abort_hex",  {11'd0, hex}, {11'd0, 7'h7F, 7'h7F, 7'b1000000});
        exp_q.delete();
        d0 = n_done;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_done", n_done - d0, 0);
        do_load(42, 1'b1);
        wait_done(cyc);
        chk("bcd_42", {20'd0, bcd}, 32'h042);
        @(negedge clk);

        // Sweep, loading in each done cycle (back-to-back)
        d0 = n_done;
        for (int v = 0; v < 256; v++) begin
            do_load(v, 1'b1);
            wait_done(cyc);
            chk("sweep_latency", cyc, 9);
        end
        @(negedge clk);
        chk("sweep_done_count", n_done - d0, 256);
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
